// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide controller.
// Op codes, default latencies, counter width and FSM states.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;
    localparam int CNT_W       = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/md_ctrl_if.sv
// Issue/result bundle between the E stage and the mul/div unit.
// master drives the request, slave returns HI/LO and status.
interface md_ctrl_if;

    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, A, B, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, A, B, flush,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/md_arith.sv
// Combinational product and quotient/remainder for the mul/div unit.
// Produces the would-be HI/LO pair and a divide-by-zero flag.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    logic               is_div;
    logic               ovf;
    logic [31:0]        dvs;
    logic signed [31:0] sa;
    logic signed [31:0] sd;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        quot_s;
    logic [31:0]        rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;

    assign is_div = (op == MD_DIV) || (op == MD_DIVU);
    assign div0   = is_div && (B == 32'd0);

    // A divisor of 1 gives the required 0x80000000 / -1 result and avoids x on /0
    assign ovf = (op == MD_DIV) && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign dvs = ((B == 32'd0) || ovf) ? 32'd1 : B;

    assign sa     = $signed(A);
    assign sd     = $signed(dvs);
    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};
    assign quot_s = 32'(sa / sd);
    assign rem_s  = 32'(sa % sd);
    assign quot_u = A / dvs;
    assign rem_u  = A % dvs;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                res_hi = rem_s;
                res_lo = quot_s;
            end
            MD_DIVU: begin
                res_hi = rem_u;
                res_lo = quot_u;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// Multi-cycle mul/div controller owning HI/LO.
// Result is captured at issue and committed when the latency counter expires.
module md_ctrl
    import md_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    md_ctrl_if.slave   bus
);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [31:0]      hi_q, hi_n;
    logic [31:0]      lo_q, lo_n;
    logic             done_q, done_n;
    logic [31:0]      rhi, rhi_n;
    logic [31:0]      rlo, rlo_n;
    logic             rz, rz_n;

    logic [31:0]      a_hi;
    logic [31:0]      a_lo;
    logic             a_div0;

    md_arith u_arith (
        .op     (bus.op),
        .A      (bus.A),
        .B      (bus.B),
        .res_hi (a_hi),
        .res_lo (a_lo),
        .div0   (a_div0)
    );

    assign bus.busy = (state == ST_RUN);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            rhi    <= '0;
            rlo    <= '0;
            rz     <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            hi_q   <= hi_n;
            lo_q   <= lo_n;
            done_q <= done_n;
            rhi    <= rhi_n;
            rlo    <= rlo_n;
            rz     <= rz_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hi_n    = hi_q;
        lo_n    = lo_q;
        done_n  = 1'b0;
        rhi_n   = rhi;
        rlo_n   = rlo;
        rz_n    = rz;
        if (bus.flush) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            MD_MULT, MD_MULTU: begin
                                rhi_n   = a_hi;
                                rlo_n   = a_lo;
                                rz_n    = a_div0;
                                cnt_n   = CNT_W'(MUL_LAT);
                                state_n = ST_RUN;
                            end
                            MD_DIV, MD_DIVU: begin
                                rhi_n   = a_hi;
                                rlo_n   = a_lo;
                                rz_n    = a_div0;
                                cnt_n   = CNT_W'(DIV_LAT);
                                state_n = ST_RUN;
                            end
                            MD_MTHI: hi_n = bus.A;
                            MD_MTLO: lo_n = bus.A;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    cnt_n = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                        if (!rz) begin
                            hi_n = rhi;
                            lo_n = rlo;
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl with a result scoreboard.
// Expected HI/LO pairs are queued at issue and popped on done.
module tb_md_ctrl;
    import md_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    md_ctrl_if bus ();

    md_ctrl #(
        .MUL_LAT (5),
        .DIV_LAT (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [63:0] sb [$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = o;
        bus.A     = a;
        bus.B     = b;
        tick();
        bus.start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
    endtask

    // Issue, count busy cycles, then check done and scoreboard head.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [63:0] exp);
        int cyc;
        logic [63:0] want;
        sb.push_back(exp);
        issue(o, a, b);
        chk({tag, "_busy_on"}, 64'(bus.busy), 64'd1);
        cyc = 0;
        while (bus.busy && cyc < 200) begin
            cyc++;
            tick();
        end
        chk({tag, "_lat"}, 64'(cyc), 64'(lat));
        chk({tag, "_done"}, 64'(bus.done), 64'd1);
        want = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        chk({tag, "_hilo"}, {bus.hi, bus.lo}, want);
    endtask

    initial begin
        int dn;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 3'd0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        #2;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5,
               64'hFFFF_FFFF_FFFF_FFFA);
        tick();
        chk("done_clear", 64'(bus.done), 64'd0);
        run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5,
               64'h0000_0001_FFFF_FFFE);
        run_op("divu", MD_DIVU, 32'd7, 32'd2, 10,
               64'h0000_0001_0000_0003);
        run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10,
               64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10,
               64'h0000_0000_8000_0000);
        tick();

        issue(MD_MTHI, 32'h1234_5678, 32'd0);
        chk("mthi_hi", 64'(bus.hi), 64'h1234_5678);
        chk("mthi_busy", 64'(bus.busy), 64'd0);
        issue(MD_MTLO, 32'h9ABC_DEF0, 32'd0);
        chk("mtlo_lo", 64'(bus.lo), 64'h9ABC_DEF0);
        chk("mtlo_busy", 64'(bus.busy), 64'd0);
        chk("mtlo_done", 64'(bus.done), 64'd0);

        run_op("div0", MD_DIV, 32'd55, 32'd0, 10,
               64'h1234_5678_9ABC_DEF0);
        tick();

        // MTLO during RUN ignored, then flush aborts the MULT
        issue(MD_MULT, 32'd5, 32'd6);
        tick();
        issue(MD_MTLO, 32'hDEAD_BEEF, 32'd0);
        chk("stall_busy", 64'(bus.busy), 64'd1);
        chk("stall_lo", 64'(bus.lo), 64'h9ABC_DEF0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_busy", 64'(bus.busy), 64'd0);
        chk("flush_done", 64'(bus.done), 64'd0);
        chk("flush_hilo", {bus.hi, bus.lo}, 64'h1234_5678_9ABC_DEF0);
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done) dn++;
        end
        chk("flush_nodone", 64'(dn), 64'd0);

        // Flush on the final RUN edge of a DIV
        issue(MD_DIV, 32'd100, 32'd7);
        for (int i = 0; i < 9; i++) tick();
        chk("lastflush_busy_pre", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("lastflush_busy", 64'(bus.busy), 64'd0);
        chk("lastflush_done", 64'(bus.done), 64'd0);
        chk("lastflush_hilo", {bus.hi, bus.lo}, 64'h1234_5678_9ABC_DEF0);

        // Asynchronous reset in the middle of a DIV
        issue(MD_DIV, 32'd100, 32'd7);
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_hilo", {bus.hi, bus.lo}, 64'd0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("arst_idle", 64'(bus.busy), 64'd0);

        run_op("mult34", MD_MULT, 32'd3, 32'd4, 5, 64'd12);
        tick();
        run_op("b2b_a", MD_MULT, 32'd7, 32'd8, 5, 64'd56);
        run_op("b2b_b", MD_MULTU, 32'd9, 32'd9, 5, 64'd81);
        tick();
        chk("b2b_done_clear", 64'(bus.done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multi-cycle multiply/divide controller for the P8 datapath, alongside the ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and owns the HI/LO registers.
- Sequences fixed-latency operations and drives a busy flag that the hazard unit uses to stall MFHI/MFLO and further mul/div instructions.
- Supports flush on exception so an in-flight operation leaves HI/LO untouched.

Parameters:
- MUL_LAT, 5, cycles busy for MULT/MULTU (>=1)
- DIV_LAT, 10, cycles busy for DIV/DIVU (>=1)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  issue strobe, sampled each rising edge
- op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; other codes are no-ops
- A  input  32  rs operand
- B  input  32  rt operand
- flush  input  1  abort any in-flight operation and discard this cycle's start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO are committed by mul/div
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, internal result latches=0. Reset asserted mid-operation aborts it immediately.
- States are IDLE and RUN. busy is registered and equals (state==RUN).
- IDLE, start=1, flush=0:
  - MULT/MULTU/DIV/DIVU: latch the operation result, load counter with MUL_LAT or DIV_LAT, go to RUN.
  - MTHI: hi<=A at that edge, stay IDLE. MTLO: lo<=A, stay IDLE. No busy and no done for MTHI/MTLO.
  - Invalid op: no effect.
- RUN: counter decrements each edge. At the edge where counter goes 1->0: commit {hi,lo}, go to IDLE, done=1 for the following cycle. busy is therefore high for exactly LAT cycles after the issue edge.
- start while RUN is ignored, including MTHI/MTLO. The hazard unit must stall; the bench checks that state is unchanged.
- flush=1 at any edge: go to IDLE, counter=0, no commit, done=0. hi/lo keep their prior values. A start in the same cycle is discarded.
- flush and the final RUN cycle coincide: flush wins and there is no commit.
- Arithmetic:
  - MULT: {hi,lo} = signed(A)*signed(B), 64-bit.
  - MULTU: unsigned 64-bit product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - B==0 for DIV/DIVU: the operation runs its full latency and asserts done, but hi/lo are unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Results are computed combinationally from A/B at the issue edge and held internally. A/B may change during RUN without affecting the result.
- done is cleared on the next edge unless another completion occurs. A new start at the cycle done=1 (state IDLE) is accepted.

Decomposition:
- Shared package md_pkg holds:
  - the op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO;
  - the default latencies;
  - the state encoding ST_IDLE, ST_RUN.
- One combinational sub-module, md_arith: inputs op, A, B; outputs res_hi, res_lo, div0 flag. It holds all signed/unsigned product and quotient logic.
- md_ctrl holds the FSM, counter, result latch and HI/LO.

Test Plan:
- Reset then MULT A=0xFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles, done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU A=0xFFFFFFFF, B=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles. DIVU A=7, B=2 -> after 10 cycles hi=1, lo=3.
- DIV A=-7 (0xFFFFFFF9), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI A=0x12345678 then MTLO A=0x9ABCDEF0 -> hi/lo update on the issue edge, busy stays 0. DIV with B=0 -> busy 10 cycles, done pulses, hi/lo still 0x12345678/0x9ABCDEF0.
- During MULT, assert start with MTLO A=0xDEADBEEF at cycle 2 -> ignored. Flush at cycle 3 -> busy drops next edge, no done, hi/lo unchanged. Flush coinciding with the last cycle of a DIV -> no commit.
- Drop rst_n mid-DIV at cycle 4 -> busy=0, hi=lo=0 immediately (asynchronously). Release reset, issue MULT 3x4 -> lo=12, hi=0. Back-to-back MULT issued in the done cycle -> accepted, busy 5 more cycles.
